// File: rtl/regfile_dump_pkg.sv
// Shared register-file constants, dump FSM state encoding and the dump word payload.
package regfile_dump_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  typedef struct packed {
    reg_addr_t index;
    reg_data_t data;
  } dump_word_t;

  // Register indices wrap modulo NUM_REGS.
  function automatic reg_addr_t next_addr(input reg_addr_t a);
    return a + REG_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Control, register-file read port and dump stream between the dumper and its environment.
interface regfile_dump_if;
  import regfile_dump_pkg::*;

  logic      start;
  logic      abort;
  reg_addr_t first_reg;
  reg_addr_t last_reg;
  reg_addr_t read_register;
  reg_data_t read_data;
  logic      dump_valid;
  logic      dump_ready;
  reg_addr_t dump_index;
  reg_data_t dump_data;
  logic      busy;
  logic      done;

  modport master (
    input  start, abort, first_reg, last_reg, read_data, dump_ready,
    output read_register, dump_valid, dump_index, dump_data, busy, done
  );

  modport slave (
    output start, abort, first_reg, last_reg, read_data, dump_ready,
    input  read_register, dump_valid, dump_index, dump_data, busy, done
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks a register range through one read port and streams (index, data) words
// over a valid/ready handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  regfile_dump_if.master bus
);

  dump_state_e state, state_n;
  reg_addr_t   idx, idx_n;
  reg_addr_t   last_q, last_n;
  dump_word_t  word_q, word_n;
  reg_addr_t   nxt;
  logic        nxt_skip;
  logic        dump_valid_q;
  logic        busy_q;
  logic        done_q;

  // Next state, range latch, capture and index advance; abort overrides everything.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    last_n   = last_q;
    word_n   = word_q;
    nxt      = next_addr(idx);
    nxt_skip = SKIP_ZERO && (nxt == '0);

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          last_n  = bus.last_reg;
          idx_n   = bus.first_reg;
          state_n = READ;
          if (SKIP_ZERO && (bus.first_reg == '0)) begin
            if (bus.last_reg == '0) state_n = DONE;
            else                    idx_n   = REG_ADDR_W'(1);
          end
        end
      end
      READ: begin
        word_n.index = idx;
        word_n.data  = bus.read_data;
        state_n      = SEND;
      end
      SEND: begin
        if (bus.dump_ready) begin
          if (idx == last_q) begin
            state_n = DONE;
          end else if (nxt_skip) begin
            // register 0 is passed over; it may itself be the range end
            if (nxt == last_q) begin
              state_n = DONE;
            end else begin
              idx_n   = REG_ADDR_W'(1);
              state_n = READ;
            end
          end else begin
            idx_n   = nxt;
            state_n = READ;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (bus.abort) state_n = IDLE;
  end

  // State, index and output registers; status flags decode the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      last_q       <= '0;
      word_q       <= '0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      last_q       <= last_n;
      word_q       <= word_n;
      dump_valid_q <= (state_n == SEND);
      busy_q       <= (state_n == READ) || (state_n == SEND);
      done_q       <= (state_n == DONE);
    end
  end

  assign bus.read_register = idx;
  assign bus.dump_valid    = dump_valid_q;
  assign bus.dump_index    = word_q.index;
  assign bus.dump_data     = word_q.data;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Drives two dumpers (SKIP_ZERO=0/1) against a behavioural register file and
// checks every dump against a range-walk model.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_dump_if bus0 ();
  regfile_dump_if bus1 ();

  logic [31:0] rf [32];
  assign bus0.read_data = rf[bus0.read_register];
  assign bus1.read_data = rf[bus1.read_register];

  regfile_dump #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_dump #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic        v;
    logic [4:0]  i;
    logic [31:0] d;
    logic        b;
    logic        dn;
    logic [4:0]  ra;
  } obs_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [4:0]  got_idx  [$];
  logic [31:0] got_data [$];
  logic [4:0]  exp_idx  [$];
  int          done_cnt;
  int          first_valid;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input bit sel, input logic st, input logic ab, input logic rdy);
    if (sel) begin bus1.start = st; bus1.abort = ab; bus1.dump_ready = rdy; end
    else     begin bus0.start = st; bus0.abort = ab; bus0.dump_ready = rdy; end
  endtask

  task automatic set_range(input bit sel, input logic [4:0] f, input logic [4:0] l);
    if (sel) begin bus1.first_reg = f; bus1.last_reg = l; end
    else     begin bus0.first_reg = f; bus0.last_reg = l; end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) o = {bus1.dump_valid, bus1.dump_index, bus1.dump_data, bus1.busy, bus1.done, bus1.read_register};
    else     o = {bus0.dump_valid, bus0.dump_index, bus0.dump_data, bus0.busy, bus0.done, bus0.read_register};
    return o;
  endfunction

  // Reference: list of indices from f to l inclusive, modulo 32, optionally without 0.
  task automatic build_exp(input logic [4:0] f, input logic [4:0] l, input bit skip);
    int k;
    k = int'(f);
    exp_idx.delete();
    for (int n = 0; n < 32; n++) begin
      if (!(skip && k == 0)) exp_idx.push_back(5'(k));
      if (k == int'(l)) break;
      k = (k + 1) % 32;
    end
  endtask

  task automatic compare_run(input string tag);
    chk(got_idx.size(), exp_idx.size(), {tag, ".count"});
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      chk(32'(got_idx[j]), 32'(exp_idx[j]), $sformatf("%s.idx[%0d]", tag, j));
      chk(got_data[j], rf[exp_idx[j]], $sformatf("%s.data[%0d]", tag, j));
    end
    chk(done_cnt, 1, {tag, ".done"});
  endtask

  // Call just after a negedge; returns just after a negedge with the DUT idle.
  task automatic run_dump(input bit sel, input logic [4:0] f, input logic [4:0] l,
                          input int ready_pct, input bit stall3, input string tag);
    obs_t o, prev;
    bit   rdy, prev_stall, finished;
    int   stall_cnt;
    got_idx.delete(); got_data.delete();
    done_cnt = 0; first_valid = -1; prev_stall = 0; finished = 0; stall_cnt = 0; prev = '0;
    set_range(sel, f, l);
    set_in(sel, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 800 && !finished; c++) begin
      @(negedge clk);
      o = sample(sel);
      if (prev_stall) begin
        chk(32'(o.v), 1, {tag, ".hold_valid"});
        chk(32'(o.i), 32'(prev.i), {tag, ".hold_index"});
        chk(o.d, prev.d, {tag, ".hold_data"});
      end
      if (o.v) chk(32'(o.b), 1, {tag, ".busy"});
      if (o.v && first_valid < 0) first_valid = c;
      if (stall3) rdy = !(o.v && o.i == 5'd3 && stall_cnt < 5);
      else        rdy = ($urandom_range(0, 99) < ready_pct);
      if (stall3 && !rdy) stall_cnt++;
      set_in(sel, 1'b0, 1'b0, rdy);
      if (o.v && rdy) begin got_idx.push_back(o.i); got_data.push_back(o.d); end
      prev_stall = o.v && !rdy;
      prev = o;
      if (o.dn) begin done_cnt++; finished = 1; end
    end
    chk(32'(finished), 1, {tag, ".timeout"});
    if (stall3) chk(stall_cnt, 5, {tag, ".stall_cycles"});
    @(negedge clk);
    o = sample(sel);
    chk(32'(o.dn), 0, {tag, ".done_once"});
    chk(32'(o.b), 0, {tag, ".idle_busy"});
    chk(32'(o.v), 0, {tag, ".idle_valid"});
  endtask

  initial begin
    obs_t       o;
    bit         hit;
    logic [4:0] rf_, rl_;
    bit         sel;

    for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h1111_1111;
    set_in(0, 1'b0, 1'b0, 1'b0); set_in(1, 1'b0, 1'b0, 1'b0);
    set_range(0, 5'd0, 5'd0);    set_range(1, 5'd0, 5'd0);

    // Reset state
    @(negedge clk); @(negedge clk);
    o = sample(0);
    chk(32'(o.v), 0, "rst.valid"); chk(32'(o.b), 0, "rst.busy"); chk(32'(o.dn), 0, "rst.done");
    chk(32'(o.i), 0, "rst.index"); chk(o.d, 0, "rst.data"); chk(32'(o.ra), 0, "rst.readreg");
    rst = 1'b0;
    @(negedge clk);

    // 1: full dump with ready held high, 2-cycle latency
    run_dump(0, 5'd0, 5'd31, 100, 0, "t1");
    build_exp(5'd0, 5'd31, 0); compare_run("t1");
    chk(first_valid, 1, "t1.latency");

    // 2: wrapping range
    run_dump(0, 5'd30, 5'd1, 100, 0, "t2");
    build_exp(5'd30, 5'd1, 0); compare_run("t2");

    // 3: backpressure on word 3
    run_dump(0, 5'd0, 5'd7, 100, 1, "t3");
    build_exp(5'd0, 5'd7, 0); compare_run("t3");

    // 4: skip register zero
    run_dump(1, 5'd31, 5'd2, 100, 0, "t4a");
    build_exp(5'd31, 5'd2, 1); compare_run("t4a");
    chk(exp_idx.size(), 3, "t4a.model");
    run_dump(1, 5'd0, 5'd0, 100, 0, "t4b");
    build_exp(5'd0, 5'd0, 1); compare_run("t4b");
    chk(first_valid, -1, "t4b.no_valid");

    // 5: abort on word 4 with ready low; spurious start/range changes ignored
    got_idx.delete(); hit = 0;
    set_range(0, 5'd0, 5'd31);
    set_in(0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      o = sample(0);
      if (c == 3) set_range(0, 5'd20, 5'd25);
      if (o.v && o.i == 5'd4) begin set_in(0, 1'b0, 1'b1, 1'b0); hit = 1; break; end
      set_in(0, (c == 3 || c == 6), 1'b0, 1'b1);
      if (o.v) got_idx.push_back(o.i);
    end
    chk(32'(hit), 1, "t5.reach_word4");
    @(negedge clk);
    o = sample(0);
    chk(32'(o.v), 0, "t5.abort_valid"); chk(32'(o.b), 0, "t5.abort_busy"); chk(32'(o.dn), 0, "t5.abort_done");
    set_in(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    o = sample(0);
    chk(32'(o.dn), 0, "t5.no_done"); chk(32'(o.b), 0, "t5.stays_idle");
    build_exp(5'd0, 5'd3, 0);
    chk(got_idx.size(), 4, "t5.count");
    for (int j = 0; j < 4 && j < got_idx.size(); j++)
      chk(32'(got_idx[j]), 32'(exp_idx[j]), $sformatf("t5.idx[%0d]", j));
    run_dump(0, 5'd10, 5'd14, 100, 0, "t5r");
    build_exp(5'd10, 5'd14, 0); compare_run("t5r");

    // 6: asynchronous reset mid-SEND
    set_range(0, 5'd7, 5'd31);
    set_in(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); set_in(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    o = sample(0);
    chk(32'(o.v), 1, "t6.in_send"); chk(32'(o.i), 7, "t6.word_index");
    #2 rst = 1'b1;
    #1;
    o = sample(0);
    chk(32'(o.v), 0, "t6.valid"); chk(32'(o.b), 0, "t6.busy"); chk(32'(o.dn), 0, "t6.done");
    chk(32'(o.i), 0, "t6.index"); chk(o.d, 0, "t6.data"); chk(32'(o.ra), 0, "t6.readreg");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    o = sample(0);
    chk(32'(o.v), 0, "t6.post_valid"); chk(32'(o.dn), 0, "t6.post_done");
    run_dump(0, 5'd5, 5'd5, 100, 0, "t6s");
    build_exp(5'd5, 5'd5, 0); compare_run("t6s");

    // Randomized ranges, data and ready on both variants
    for (int it = 0; it < 10; it++) begin
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      rf[0] = 32'h0;
      rf_ = 5'($urandom_range(0, 31));
      rl_ = 5'($urandom_range(0, 31));
      sel = it[0];
      run_dump(sel, rf_, rl_, int'($urandom_range(30, 100)), 0, $sformatf("rnd%0d", it));
      build_exp(rf_, rl_, sel); compare_run($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
